alu_branch_unit: RTL and testbench
==================================

ALU_BRANCH_UNIT -- requirements
Module: alu_branch_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have i_clk  input  1  clock, rising-edge.
REQ-003 SHALL have i_rst  input  1  reset: synchronous, active-low, sampled on i_clk rising edge.
REQ-004 SHALL have i_ALUOp  input  3  operation class from main control.
REQ-005 SHALL have i_Funct3  input  3  instr[14:12].
REQ-006 SHALL have i_Funct7  input  7  instr[31:25]; only bit 5 used.
REQ-007 SHALL have i_Branch  input  1  instruction is a conditional branch.
REQ-008 SHALL have i_A, i_B  input  XLEN  operands A and B.
REQ-009 SHALL have o_ALUCtrl  output  4  decoded ALU operation.
REQ-010 SHALL have o_Res  output  XLEN  ALU result.
REQ-011 SHALL have o_Z  output  1  high when o_Res == 0.
REQ-012 SHALL have o_DoBranch  output  1  branch taken.

Function
REQ-013 SHALL use these ALU op codes: 0000 ADD, 0001 SUB, 0010 SLL, 0011 SLT, 0100 SLTU, 0101 XOR, 0110 SRL, 0111 SRA, 1000 OR, 1001 AND, 1010 PASS_B; codes 1011-1111 give result 0.
REQ-014 SHALL decode ALUOp 000 to ADD (loads, stores, AUIPC, JAL/JALR, LUI with A=0).
REQ-015 SHALL decode ALUOp 001 (branch) by funct3: 000/001 to SUB, 100/101 to SLT, 110/111 to SLTU, 010/011 to SUB.
REQ-016 SHALL decode ALUOp 010 (R-type) by funct3: 000 gives ADD, or SUB when funct7[5]=1; 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 gives SRL, or SRA when funct7[5]=1; 110 OR; 111 AND.
REQ-017 SHALL decode ALUOp 011 (I-type) the same as 010, except funct3 000 always gives ADD.
REQ-018 SHALL decode ALUOp 100 to PASS_B, and ALUOp 101-111 to ADD.
REQ-019 SHALL perform ADD/SUB modulo 2^XLEN with the carry discarded.
REQ-020 SHALL take the shift amount from i_B[4:0]; SRA replicates i_A[XLEN-1].
REQ-021 SHALL make SLT a signed compare and SLTU an unsigned compare; result 1 or 0, zero-extended.
REQ-022 SHALL set o_DoBranch = i_Branch AND condition, where condition by funct3 is: 000 Z; 001 !Z; 100 Res[0]; 101 !Res[0]; 110 Res[0]; 111 !Res[0]; 010/011 0.
REQ-023 SHALL force o_DoBranch to 0 whenever i_Branch=0, regardless of funct3.
REQ-024 SHALL, without the configuration macro, be purely combinational (zero latency); i_clk and i_rst are then unused.

Reset
REQ-025 SHALL, when the output register stage is compiled in and i_rst=0 at a rising edge, clear o_Res, o_Z, o_DoBranch and o_ALUCtrl to 0.
REQ-026 SHALL give reset priority over the capture of new results; a reset arriving mid-stream discards the in-flight result.

Configuration
REQ-027 SHALL support the macro ALU_BRANCH_OUTREG_EN: when it is defined, all four outputs are registered on the i_clk rising edge, giving 1-cycle latency.
REQ-028 SHALL, when ALU_BRANCH_OUTREG_EN is undefined, drive the outputs combinationally, with no flops and no reset logic.

Structure
REQ-029 SHALL place the ALU op-code constants, the ALUOp class constants and the branch funct3 constants in the shared package alu_pkg.
REQ-030 SHALL implement the arithmetic/logic datapath as one sub-module, alu_core (ops, A, B -> result, zero), instantiated once.
REQ-031 SHALL keep the ALU-control decode and the branch-condition logic inline in alu_branch_unit.

Verification
REQ-032 SHALL verify R-type SUB: ALUOp=010, f3=000, f7=0100000, A=5, B=5 -> ALUCtrl=0001, Res=0, Z=1.
REQ-033 SHALL verify branch BLT: Branch=1, ALUOp=001, f3=100, A=0xFFFFFFFF, B=1 -> Res=1, DoBranch=1; with f3=110 (BLTU) -> Res=0, DoBranch=0.
REQ-034 SHALL verify SRAI: ALUOp=011, f3=101, f7=0100000, A=0x80000000, B=4 -> Res=0xF8000000; with f7=0 -> Res=0x08000000.
REQ-035 SHALL verify I-type ADDI and the Branch gate: ALUOp=011, f3=000, f7=0100000, A=7, B=1 -> ADD, Res=8; Branch=0, f3=000, Z=1 -> DoBranch=0.
REQ-036 SHALL verify ADD overflow and BNE: A=0xFFFFFFFF, B=1, ALUOp=000 -> Res=0, Z=1; BNE (f3=001, Branch=1) with A=3, B=3 -> DoBranch=0.
REQ-037 SHALL verify, with ALU_BRANCH_OUTREG_EN defined, that outputs appear one cycle after inputs, and that i_rst=0 for one edge drives all outputs to 0.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared constants for the ALU/branch unit
// Purpose: ALU operation codes, main-control ALUOp classes and branch funct3
// encodings used by alu_branch_unit and alu_core.
// Ports: none (package).
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'b0000,
        ALU_SUB    = 4'b0001,
        ALU_SLL    = 4'b0010,
        ALU_SLT    = 4'b0011,
        ALU_SLTU   = 4'b0100,
        ALU_XOR    = 4'b0101,
        ALU_SRL    = 4'b0110,
        ALU_SRA    = 4'b0111,
        ALU_OR     = 4'b1000,
        ALU_AND    = 4'b1001,
        ALU_PASS_B = 4'b1010
    } alu_op_e;

    localparam logic [2:0] ALUOP_ADD    = 3'b000;
    localparam logic [2:0] ALUOP_BRANCH = 3'b001;
    localparam logic [2:0] ALUOP_RTYPE  = 3'b010;
    localparam logic [2:0] ALUOP_ITYPE  = 3'b011;
    localparam logic [2:0] ALUOP_PASS_B = 3'b100;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - arithmetic/logic datapath
// Purpose: computes the result for one 4-bit ALU op code and flags a zero result.
// Ports:
//   i_op   [3:0]      ALU op code (alu_op_e encoding; unused codes give 0)
//   i_a    [XLEN-1:0] operand A
//   i_b    [XLEN-1:0] operand B (B[4:0] is the shift amount)
//   o_res  [XLEN-1:0] result
//   o_zero            high when o_res is all zeros
module alu_core
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [3:0]      i_op,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic [XLEN-1:0] o_res,
    output logic            o_zero
);

    logic [4:0] shamt;
    logic       lt_signed;
    logic       lt_unsigned;

    assign shamt       = i_b[4:0];
    assign lt_signed   = $signed(i_a) < $signed(i_b);
    assign lt_unsigned = i_a < i_b;

    always_comb begin
        o_res = '0;
        case (i_op)
            ALU_ADD:    o_res = i_a + i_b;
            ALU_SUB:    o_res = i_a - i_b;
            ALU_SLL:    o_res = i_a << shamt;
            ALU_SLT:    o_res = {{(XLEN-1){1'b0}}, lt_signed};
            ALU_SLTU:   o_res = {{(XLEN-1){1'b0}}, lt_unsigned};
            ALU_XOR:    o_res = i_a ^ i_b;
            ALU_SRL:    o_res = i_a >> shamt;
            ALU_SRA:    o_res = $unsigned($signed(i_a) >>> shamt);
            ALU_OR:     o_res = i_a | i_b;
            ALU_AND:    o_res = i_a & i_b;
            ALU_PASS_B: o_res = i_b;
            default:    o_res = '0;
        endcase
    end

    assign o_zero = (o_res == '0);

endmodule

// File: rtl/alu_branch_unit.sv
// rtl/alu_branch_unit.sv - ALU control decode, datapath and branch decision
// Purpose: decodes ALUOp/funct3/funct7 into an ALU op, runs alu_core and
// resolves conditional branches from the result.
// Optional output register stage: define ALU_BRANCH_OUTREG_EN to register all
// outputs on i_clk (1-cycle latency, synchronous active-low i_rst clears them).
// Without it the unit is purely combinational and i_clk/i_rst are unused.
// Ports:
//   i_clk, i_rst         clock, synchronous active-low reset
//   i_ALUOp [2:0]        operation class from main control
//   i_Funct3 [2:0]       instr[14:12]
//   i_Funct7 [6:0]       instr[31:25] (bit 5 selects SUB/SRA)
//   i_Branch             instruction is a conditional branch
//   i_A, i_B [XLEN-1:0]  operands
//   o_ALUCtrl [3:0]      decoded ALU operation
//   o_Res [XLEN-1:0]     ALU result
//   o_Z                  result is zero
//   o_DoBranch           branch taken
module alu_branch_unit
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [2:0]      i_ALUOp,
    input  logic [2:0]      i_Funct3,
    input  logic [6:0]      i_Funct7,
    input  logic            i_Branch,
    input  logic [XLEN-1:0] i_A,
    input  logic [XLEN-1:0] i_B,
    output logic [3:0]      o_ALUCtrl,
    output logic [XLEN-1:0] o_Res,
    output logic            o_Z,
    output logic            o_DoBranch
);

    logic [3:0]      alu_ctrl;
    logic [XLEN-1:0] res;
    logic            zero;
    logic            cond;
    logic            do_branch;
    logic            f7_alt;

    assign f7_alt = i_Funct7[5];

    // R-type and I-type share the funct3 map; only I-type ignores funct7[5]
    // on funct3 000 since ADDI has no subtract form.
    always_comb begin
        alu_ctrl = ALU_ADD;
        case (i_ALUOp)
            ALUOP_ADD: alu_ctrl = ALU_ADD;
            ALUOP_BRANCH: begin
                case (i_Funct3)
                    F3_BLT, F3_BGE:   alu_ctrl = ALU_SLT;
                    F3_BLTU, F3_BGEU: alu_ctrl = ALU_SLTU;
                    default:          alu_ctrl = ALU_SUB;
                endcase
            end
            ALUOP_RTYPE, ALUOP_ITYPE: begin
                case (i_Funct3)
                    3'b000:  alu_ctrl = (i_ALUOp == ALUOP_RTYPE && f7_alt) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_ctrl = ALU_SLL;
                    3'b010:  alu_ctrl = ALU_SLT;
                    3'b011:  alu_ctrl = ALU_SLTU;
                    3'b100:  alu_ctrl = ALU_XOR;
                    3'b101:  alu_ctrl = f7_alt ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_ctrl = ALU_OR;
                    default: alu_ctrl = ALU_AND;
                endcase
            end
            ALUOP_PASS_B: alu_ctrl = ALU_PASS_B;
            default:      alu_ctrl = ALU_ADD;
        endcase
    end

    alu_core #(.XLEN(XLEN)) u_alu_core (
        .i_op   (alu_ctrl),
        .i_a    (i_A),
        .i_b    (i_B),
        .o_res  (res),
        .o_zero (zero)
    );

    // Less-than branches read the SLT/SLTU bit; equality branches read Z.
    always_comb begin
        cond = 1'b0;
        case (i_Funct3)
            F3_BEQ:           cond = zero;
            F3_BNE:           cond = ~zero;
            F3_BLT, F3_BLTU:  cond = res[0];
            F3_BGE, F3_BGEU:  cond = ~res[0];
            default:          cond = 1'b0;
        endcase
    end

    assign do_branch = i_Branch & cond;

`ifdef ALU_BRANCH_OUTREG_EN
    logic [3:0]      alu_ctrl_d, alu_ctrl_q;
    logic [XLEN-1:0] res_d, res_q;
    logic            z_d, z_q;
    logic            do_branch_d, do_branch_q;

    // Reset wins over capture so a result in flight is dropped.
    always_comb begin
        alu_ctrl_d  = alu_ctrl;
        res_d       = res;
        z_d         = zero;
        do_branch_d = do_branch;
        if (!i_rst) begin
            alu_ctrl_d  = '0;
            res_d       = '0;
            z_d         = 1'b0;
            do_branch_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        alu_ctrl_q  <= alu_ctrl_d;
        res_q       <= res_d;
        z_q         <= z_d;
        do_branch_q <= do_branch_d;
    end

    assign o_ALUCtrl  = alu_ctrl_q;
    assign o_Res      = res_q;
    assign o_Z        = z_q;
    assign o_DoBranch = do_branch_q;

    logic unused_bits;
    assign unused_bits = &{1'b0, i_Funct7[6], i_Funct7[4:0]};
`else
    assign o_ALUCtrl  = alu_ctrl;
    assign o_Res      = res;
    assign o_Z        = zero;
    assign o_DoBranch = do_branch;

    logic unused_bits;
    assign unused_bits = &{1'b0, i_clk, i_rst, i_Funct7[6], i_Funct7[4:0]};
`endif

endmodule

// File: tb/tb_alu_branch_unit.sv
// tb/tb_alu_branch_unit.sv - scoreboard bench for alu_branch_unit
module tb_alu_branch_unit;

    localparam int XLEN = 32;
`ifdef ALU_BRANCH_OUTREG_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    logic            i_clk = 1'b0;
    logic            i_rst = 1'b0;
    logic [2:0]      i_ALUOp = '0;
    logic [2:0]      i_Funct3 = '0;
    logic [6:0]      i_Funct7 = '0;
    logic            i_Branch = 1'b0;
    logic [XLEN-1:0] i_A = '0;
    logic [XLEN-1:0] i_B = '0;
    logic [3:0]      o_ALUCtrl;
    logic [XLEN-1:0] o_Res;
    logic            o_Z;
    logic            o_DoBranch;

    alu_branch_unit #(.XLEN(XLEN)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_ALUOp    (i_ALUOp),
        .i_Funct3   (i_Funct3),
        .i_Funct7   (i_Funct7),
        .i_Branch   (i_Branch),
        .i_A        (i_A),
        .i_B        (i_B),
        .o_ALUCtrl  (o_ALUCtrl),
        .o_Res      (o_Res),
        .o_Z        (o_Z),
        .o_DoBranch (o_DoBranch)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        string       name;
        logic [3:0]  ctrl;
        logic [31:0] res;
        logic        z;
        logic        br;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s actual=%h expected=%h", nm, fld, act, exp);
        end
    endtask

    // Monitor: compares every expectation whose output cycle has arrived.
    always @(negedge i_clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            chk(e.name, "ctrl", {28'd0, o_ALUCtrl}, {28'd0, e.ctrl});
            chk(e.name, "res",  o_Res, e.res);
            chk(e.name, "z",    {31'd0, o_Z}, {31'd0, e.z});
            chk(e.name, "br",   {31'd0, o_DoBranch}, {31'd0, e.br});
        end
    end

    task automatic apply(input string nm, input logic rst, input logic [2:0] op,
                         input logic [2:0] f3, input logic [6:0] f7, input logic br,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] ectrl, input logic [31:0] eres,
                         input logic ez, input logic ebr);
        exp_t e;
        @(posedge i_clk);
        #1;
        i_rst = rst; i_ALUOp = op; i_Funct3 = f3; i_Funct7 = f7;
        i_Branch = br; i_A = a; i_B = b;
        e.name = nm; e.ctrl = ectrl; e.res = eres; e.z = ez; e.br = ebr;
        e.due = cyc + LAT;
        if (LAT == 1 && rst == 1'b0) begin
            e.ctrl = 4'd0; e.res = 32'd0; e.z = 1'b0; e.br = 1'b0;
        end
        sb.push_back(e);
    endtask

    initial begin
        repeat (2) @(posedge i_clk);
        //      name        rst  op      f3      f7          br  A             B             ctrl   res           z  br
        apply("reset",      0, 3'b000, 3'b000, 7'h00,      0, 32'd0,        32'd0,        4'h0, 32'd0,        1, 0);
        apply("sub_r",      1, 3'b010, 3'b000, 7'b0100000, 0, 32'd5,        32'd5,        4'h1, 32'd0,        1, 0);
        apply("blt",        1, 3'b001, 3'b100, 7'h00,      1, 32'hFFFFFFFF, 32'd1,        4'h3, 32'd1,        0, 1);
        apply("bltu",       1, 3'b001, 3'b110, 7'h00,      1, 32'hFFFFFFFF, 32'd1,        4'h4, 32'd0,        1, 0);
        apply("srai",       1, 3'b011, 3'b101, 7'b0100000, 0, 32'h80000000, 32'd4,        4'h7, 32'hF8000000, 0, 0);
        apply("srli",       1, 3'b011, 3'b101, 7'h00,      0, 32'h80000000, 32'd4,        4'h6, 32'h08000000, 0, 0);
        apply("addi",       1, 3'b011, 3'b000, 7'b0100000, 0, 32'd7,        32'd1,        4'h0, 32'd8,        0, 0);
        apply("br_gate",    1, 3'b001, 3'b000, 7'h00,      0, 32'd3,        32'd3,        4'h1, 32'd0,        1, 0);
        apply("add_ovf",    1, 3'b000, 3'b000, 7'h00,      0, 32'hFFFFFFFF, 32'd1,        4'h0, 32'd0,        1, 0);
        apply("bne",        1, 3'b001, 3'b001, 7'h00,      1, 32'd3,        32'd3,        4'h1, 32'd0,        1, 0);
        apply("beq",        1, 3'b001, 3'b000, 7'h00,      1, 32'd3,        32'd3,        4'h1, 32'd0,        1, 1);
        apply("bge",        1, 3'b001, 3'b101, 7'h00,      1, 32'd5,        32'd2,        4'h3, 32'd0,        1, 1);
        apply("bgeu_nt",    1, 3'b001, 3'b111, 7'h00,      1, 32'd1,        32'hFFFFFFFF, 4'h4, 32'd1,        0, 0);
        apply("br_f3_010",  1, 3'b001, 3'b010, 7'h00,      1, 32'd3,        32'd3,        4'h1, 32'd0,        1, 0);
        apply("pass_b",     1, 3'b100, 3'b000, 7'h00,      0, 32'd1,        32'h1234,     4'hA, 32'h1234,     0, 0);
        apply("or",         1, 3'b010, 3'b110, 7'h00,      0, 32'hF0,       32'h0F,       4'h8, 32'hFF,       0, 0);
        apply("and",        1, 3'b010, 3'b111, 7'h00,      0, 32'hF0,       32'h0F,       4'h9, 32'h0,        1, 0);
        apply("xor",        1, 3'b010, 3'b100, 7'h00,      0, 32'hF0,       32'hFF,       4'h5, 32'h0F,       0, 0);
        apply("sll31",      1, 3'b010, 3'b001, 7'h00,      0, 32'd1,        32'd31,       4'h2, 32'h80000000, 0, 0);
        apply("sll_b33",    1, 3'b011, 3'b001, 7'h00,      0, 32'd1,        32'd33,       4'h2, 32'd2,        0, 0);
        apply("sltu_r",     1, 3'b010, 3'b011, 7'h00,      0, 32'd1,        32'hFFFFFFFF, 4'h4, 32'd1,        0, 0);
        apply("slt_r",      1, 3'b010, 3'b010, 7'h00,      0, 32'd1,        32'hFFFFFFFF, 4'h3, 32'd0,        1, 0);
        apply("aluop111",   1, 3'b111, 3'b101, 7'b0100000, 0, 32'd2,        32'd3,        4'h0, 32'd5,        0, 0);
        apply("pre_rst",    1, 3'b001, 3'b100, 7'h00,      1, 32'hFFFFFFFF, 32'd1,        4'h3, 32'd1,        0, 1);
        apply("mid_rst",    0, 3'b001, 3'b100, 7'h00,      1, 32'hFFFFFFFF, 32'd1,        4'h3, 32'd1,        0, 1);
        apply("post_rst",   1, 3'b010, 3'b000, 7'h00,      0, 32'd9,        32'd9,        4'h0, 32'd18,       0, 0);
        repeat (3) @(posedge i_clk);
        #2;
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain pending=%0d required=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog time_limit_reached");
        $fatal(1, "timeout");
    end

endmodule
